mux_4to1: RTL and testbench
===========================

# mux_4to1

Registered 4-input, 32-bit-wide word selector used wherever the datapath picks one of four operand sources (ALU operand and result muxing). One of `in0`..`in3` is selected by a 2-bit `sel` and captured into an output register on the clock edge. Qualification with `in_valid`/`out_valid` lets downstream stages tell fresh results from held values.

## Interface
- `WIDTH`, default 32, data width of every input and of `out`.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in0`  input  WIDTH  data source selected when `sel`=2'b00.
- `in1`  input  WIDTH  data source selected when `sel`=2'b01.
- `in2`  input  WIDTH  data source selected when `sel`=2'b10.
- `in3`  input  WIDTH  data source selected when `sel`=2'b11.
- `sel`  input  2  source select.
- `in_valid`  input  1  inputs and `sel` are valid this cycle; capture enable.
- `out`  output  WIDTH  registered selected word.
- `out_sel`  output  2  registered copy of the `sel` value that produced `out`.
- `out_valid`  output  1  `out` was loaded on the most recent edge.
- `out_parity`  output  1  even parity of `out`. Present only with `MUX_4TO1_PARITY_EN`.

## Operation
- Selection: `sel`=0 chooses `in0`, 1 chooses `in1`, 2 chooses `in2`, 3 chooses `in3`. All four codes are legal, with no default or error case.
- Selection is a full-width bitwise pass-through, with no arithmetic, truncation or extension.
- Rising `clk` edge with `in_valid`=1 updates three registers:
  - `out` <= selected input;
  - `out_sel` <= `sel`;
  - `out_valid` <= 1.
- Rising `clk` edge with `in_valid`=0:
  - `out` and `out_sel` hold their previous values;
  - `out_valid` <= 0.
- X/Z on an unselected input does not affect `out`.
- No back-pressure. The block accepts a new word every cycle, and there is no ready signal.

## Timing
- Latency is exactly 1 clock from capture edge to `out`/`out_sel`/`out_valid`. Throughput is 1 word per cycle.
- Reset values: `out`=0, `out_sel`=2'b00, `out_valid`=0, `out_parity`=0.
- Reset takes effect immediately on `rst` rising, without waiting for a clock edge.
- Reset held high: outputs stay at reset values regardless of `clk`, `in_valid` or data.
- Reset deasserted: the first capture happens on the first rising `clk` edge where `rst`=0 and `in_valid`=1.
- Reset mid-stream: a capture in flight is discarded, and `out_valid` reads 0 until the next valid capture.
- Inputs and `sel` changing between edges have no effect on outputs. Outputs change only on a clock edge or on reset.
- Back-to-back valid cycles with different `sel` produce the corresponding sequence on `out` with no bubbles.

## Configuration
- `MUX_4TO1_PARITY_EN` defined:
  - port `out_parity` exists;
  - it is registered alongside `out` and updates under the same `in_valid` rule;
  - its value is the XOR-reduction of the selected word, so `out_parity` equals XOR of all bits of `out` at all times.
- `MUX_4TO1_PARITY_EN` undefined: the port and its register are absent, and all other behaviour is identical.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with `out`=32'hDEADBEEF. `out` becomes 0, `out_valid` 0 and `out_sel` 0 immediately, before any clock edge.
- Each select code, with `in0`=32'h11111111, `in1`=32'h22222222, `in2`=32'h33333333, `in3`=32'h44444444 and `in_valid`=1:
  - `sel` 0, 1, 2, 3 on consecutive cycles;
  - one cycle later `out` = 11111111, 22222222, 33333333, 44444444 and `out_sel` = 0, 1, 2, 3;
  - `out_valid` stays 1 throughout.
- Hold: capture `sel`=2 (`out`=33333333), then drive `in_valid`=0 while changing all inputs to random values and `sel` to 0. `out` stays 33333333, `out_sel` stays 2, and `out_valid` drops to 0 after one edge.
- Random sweep: 10 cycles of random 32-bit `in0`..`in3` and random `sel` in 0..3, `in_valid`=1. Each cycle, `out` equals the previous cycle's selected input.
- Unselected X: `in1`=32'hXXXXXXXX, `sel`=0, `in0`=32'h0000A5A5. `out`=32'h0000A5A5 with no X.
- Parity (macro defined): select 32'h00000007, then `out_parity`=1; select 32'h00000003, then `out_parity`=0.

Source files
------------

// File: rtl/mux_4to1_if.sv
// Bus bundle for the registered 4:1 word selector: four data sources, select and
// qualifier in, registered word/select/valid out. out_parity exists with MUX_4TO1_PARITY_EN.
interface mux_4to1_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [1:0]       sel;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic [1:0]       out_sel;
  logic             out_valid;
`ifdef MUX_4TO1_PARITY_EN
  logic             out_parity;

  modport master (
    output in0, in1, in2, in3, sel, in_valid,
    input  out, out_sel, out_valid, out_parity
  );

  modport slave (
    input  in0, in1, in2, in3, sel, in_valid,
    output out, out_sel, out_valid, out_parity
  );
`else
  modport master (
    output in0, in1, in2, in3, sel, in_valid,
    input  out, out_sel, out_valid
  );

  modport slave (
    input  in0, in1, in2, in3, sel, in_valid,
    output out, out_sel, out_valid
  );
`endif
endinterface

// File: rtl/mux_4to1.sv
// Registered 4-input word selector with valid qualification; optional even-parity
// output register enabled by defining MUX_4TO1_PARITY_EN.
module mux_4to1 #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mux_4to1_if.slave   bus
);

  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] out_d,     out_q;
  logic [1:0]       out_sel_d, out_sel_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    // NOTE: default first so no path through the block can infer a latch.
    sel_word = '0;
    case (bus.sel)
      2'b00: sel_word = bus.in0;
      2'b01: sel_word = bus.in1;
      2'b10: sel_word = bus.in2;
      2'b11: sel_word = bus.in3;
      default: sel_word = '0;
    endcase
  end

  // Word and select hold when not qualified; valid always follows in_valid.
  always_comb begin
    out_d       = bus.in_valid ? sel_word : out_q;
    out_sel_d   = bus.in_valid ? bus.sel  : out_sel_q;
    out_valid_d = bus.in_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_sel_q   <= 2'b00;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

`ifdef MUX_4TO1_PARITY_EN
  logic parity_d, parity_q;

  always_comb begin
    parity_d = bus.in_valid ? ^sel_word : parity_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign bus.out_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Self-checking bench for mux_4to1: directed scenarios plus randomized traffic
// checked against an array-indexed reference model.
module tb_mux_4to1;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_4to1_if #(.WIDTH(W)) bus ();
  mux_4to1 #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: what the outputs should show after the last edge.
  logic [W-1:0] m_out;
  logic [1:0]   m_sel;
  logic         m_valid;

  task automatic drive(input logic [W-1:0] a, b, c, d, input logic [1:0] s, input logic v);
    bus.in0 = a; bus.in1 = b; bus.in2 = c; bus.in3 = d;
    bus.sel = s; bus.in_valid = v;
  endtask

  task automatic drive_random(input logic v);
    drive($urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), v);
  endtask

  // Advance one rising edge, update the model from the sampled inputs, settle.
  task automatic tick();
    logic [W-1:0] words [4];
    @(posedge clk);
    words = '{bus.in0, bus.in1, bus.in2, bus.in3};
    if (rst) begin
      m_out = '0; m_sel = 2'b00; m_valid = 1'b0;
    end else begin
      m_valid = bus.in_valid;
      if (bus.in_valid) begin
        m_out = words[bus.sel];
        m_sel = bus.sel;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('0, '0, '0, '0, 2'b00, 1'b0);
    m_out = '0; m_sel = 2'b00; m_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.out !== '0 || bus.out_sel !== 2'b00 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_initial: out=%h sel=%0d valid=%b, want 0/0/0", bus.out, bus.out_sel, bus.out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      drive_random(1'b1);
      tick();
      n_cmp++;
      if (bus.out !== '0 || bus.out_sel !== 2'b00 || bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_held: out=%h sel=%0d valid=%b, want 0/0/0", bus.out, bus.out_sel, bus.out_valid);
      end
    end
    rst = 1'b0;
    drive(32'hDEADBEEF, '0, '0, '0, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if (bus.out !== 32'hDEADBEEF || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL reset_precapture: out=%h valid=%b, want deadbeef/1", bus.out, bus.out_valid);
    end
    // Capture in flight, then reset mid-cycle before the edge that would load it.
    drive(32'h12345678, 32'h9ABCDEF0, '0, '0, 2'b01, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    m_out = '0; m_sel = 2'b00; m_valid = 1'b0;
    n_cmp++;
    if (bus.out !== '0 || bus.out_sel !== 2'b00 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: out=%h sel=%0d valid=%b, want 0/0/0", bus.out, bus.out_sel, bus.out_valid);
    end
    tick();
    rst = 1'b0;
    drive('0, '0, '0, '0, 2'b00, 1'b0);
    tick();
    n_cmp++;
    if (bus.out !== '0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: out=%h valid=%b, want 0/0", bus.out, bus.out_valid);
    end
  endtask

  task automatic test_select_codes();
    for (int s = 0; s < 4; s++) begin
      drive(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 2'(s), 1'b1);
      tick();
      n_cmp++;
      if (bus.out !== 32'h11111111 * (s + 1) || bus.out_sel !== 2'(s) || bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL select_%0d: out=%h sel=%0d valid=%b, want %h/%0d/1",
                 s, bus.out, bus.out_sel, bus.out_valid, 32'h11111111 * (s + 1), s);
      end
    end
  endtask

  task automatic test_hold();
    drive(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 2'b10, 1'b1);
    tick();
    drive($urandom, $urandom, $urandom, $urandom, 2'b00, 1'b0);
    #2;
    n_cmp++;
    if (bus.out !== 32'h33333333 || bus.out_sel !== 2'b10 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL hold_between_edges: out=%h sel=%0d valid=%b, want 33333333/2/1", bus.out, bus.out_sel, bus.out_valid);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      drive_random(1'b0);
      n_cmp++;
      if (bus.out !== 32'h33333333 || bus.out_sel !== 2'b10 || bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold_edge_%0d: out=%h sel=%0d valid=%b, want 33333333/2/0", i, bus.out, bus.out_sel, bus.out_valid);
      end
    end
  endtask

  task automatic test_random(input int cycles, input bit mix_valid);
    for (int i = 0; i < cycles; i++) begin
      drive_random(mix_valid ? 1'($urandom_range(0, 1)) : 1'b1);
      tick();
      n_cmp++;
      if (bus.out !== m_out || bus.out_sel !== m_sel || bus.out_valid !== m_valid) begin
        n_err++;
        $display("FAIL random_%0d: out=%h sel=%0d valid=%b, want %h/%0d/%b",
                 i, bus.out, bus.out_sel, bus.out_valid, m_out, m_sel, m_valid);
      end
`ifdef MUX_4TO1_PARITY_EN
      n_cmp++;
      if (bus.out_parity !== ^m_out) begin
        n_err++;
        $display("FAIL random_parity_%0d: parity=%b, want %b", i, bus.out_parity, ^m_out);
      end
`endif
    end
  endtask

  task automatic test_unselected_x();
    drive(32'h0000A5A5, 'x, 'x, 'x, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if (bus.out !== 32'h0000A5A5 || $isunknown(bus.out)) begin
      n_err++;
      $display("FAIL unselected_x: out=%h, want 0000a5a5", bus.out);
    end
  endtask

`ifdef MUX_4TO1_PARITY_EN
  task automatic test_parity();
    drive(32'h00000007, $urandom, $urandom, $urandom, 2'b00, 1'b1);
    tick();
    n_cmp++;
    if (bus.out_parity !== 1'b1) begin
      n_err++;
      $display("FAIL parity_7: parity=%b, want 1", bus.out_parity);
    end
    drive($urandom, $urandom, $urandom, 32'h00000003, 2'b11, 1'b1);
    tick();
    n_cmp++;
    if (bus.out_parity !== 1'b0) begin
      n_err++;
      $display("FAIL parity_3: parity=%b, want 0", bus.out_parity);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_select_codes();
    test_hold();
    test_random(10, 1'b0);
    test_random(30, 1'b1);
    test_unselected_x();
`ifdef MUX_4TO1_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
